// File: rtl/mem_refill_arbiter_if.sv
// Signal bundle for mem_refill_arbiter: cache miss requests, backing-store write port
// and the two refill output channels.
interface mem_refill_arbiter_if;
    logic         ICacheMiss;
    logic [4:0]   ICacheMiss_tag;
    logic         DCacheMiss;
    logic [4:0]   DCacheMiss_tag;
    logic         mem_we;
    logic [4:0]   mem_waddr;
    logic [127:0] mem_wdata;
    logic         WiCache;
    logic [127:0] WiCacheline;
    logic [8:0]   WiCachetag;
    logic         WDCache;
    logic [127:0] WDCacheline;
    logic [8:0]   WDCachetag;
    logic         busy;

    modport slave (
        input  ICacheMiss, ICacheMiss_tag, DCacheMiss, DCacheMiss_tag,
        input  mem_we, mem_waddr, mem_wdata,
        output WiCache, WiCacheline, WiCachetag,
        output WDCache, WDCacheline, WDCachetag,
        output busy
    );

    modport master (
        output ICacheMiss, ICacheMiss_tag, DCacheMiss, DCacheMiss_tag,
        output mem_we, mem_waddr, mem_wdata,
        input  WiCache, WiCacheline, WiCachetag,
        input  WDCache, WDCacheline, WDCachetag,
        input  busy
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Arbitrates instruction/data cache misses onto a 32x128 backing store and returns one refill
// strobe LATENCY edges after capture. Define ARB_ROUND_ROBIN_EN for round-robin on ties.
module mem_refill_arbiter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_refill_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StWait, StFill, StDone} state_e;

    localparam logic [3:0] LatencyInit = 4'(LATENCY);

    logic [127:0] store [32];

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         side_q, side_d;  // 1 = data side owns the current refill
    logic [4:0]   tag_q, tag_d;
    logic [127:0] line_q, line_d;
    logic         any_miss;
    logic         grant_data;
    logic [127:0] fill_line;
    logic         fill_i, fill_d;

    assign any_miss = bus.ICacheMiss | bus.DCacheMiss;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q;  // data side won the most recent capture

    assign grant_data = bus.DCacheMiss & (~bus.ICacheMiss | ~last_data_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_data_q <= 1'b0;
        end else if (state_q == StIdle && any_miss) begin
            last_data_q <= grant_data;
        end
    end
`else
    assign grant_data = bus.DCacheMiss;
`endif

    // Backing store survives reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && bus.mem_we) begin
            store[bus.mem_waddr] <= bus.mem_wdata;
        end
    end

    // Write-first: a same-edge store write to the latched index is forwarded into the fill.
    assign fill_line = (bus.mem_we && bus.mem_waddr == tag_q) ? bus.mem_wdata : store[tag_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            side_q  <= 1'b0;
            tag_q   <= 5'd0;
            line_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            side_q  <= side_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        side_d  = side_q;
        tag_d   = tag_q;
        line_d  = line_q;
        case (state_q)
            StIdle: begin
                if (any_miss) begin
                    side_d  = grant_data;
                    tag_d   = grant_data ? bus.DCacheMiss_tag : bus.ICacheMiss_tag;
                    cnt_d   = LatencyInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    line_d  = fill_line;
                    state_d = StFill;
                end
            end
            StFill:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign fill_i = (state_q == StFill) & ~side_q;
    assign fill_d = (state_q == StFill) & side_q;

    assign bus.WiCache     = fill_i;
    assign bus.WiCacheline = fill_i ? line_q : 128'd0;
    assign bus.WiCachetag  = fill_i ? {4'b0000, tag_q} : 9'd0;
    assign bus.WDCache     = fill_d;
    assign bus.WDCacheline = fill_d ? line_q : 128'd0;
    assign bus.WDCachetag  = fill_d ? {4'b0000, tag_q} : 9'd0;
    assign bus.busy        = (state_q != StIdle);
endmodule
